// File: rtl/mem_pkg.sv
// Shared definitions for the burst initiator of the 16x8 synchronous memory port:
// geometry constants, read pipeline latency and the controller state encoding.
package mem_pkg;

  localparam int MEM_AW       = 4;
  localparam int MEM_DW       = 8;
  localparam int READ_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_burst_rd_pipe.sv
// Read return path: a READ_LATENCY-deep valid shift register plus the rd_data
// capture register. flush_i (tied to reset) discards every beat in flight.
module mem_burst_rd_pipe
  import mem_pkg::*;
#(
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          flush_i,
  input  logic          issue_i,
  input  logic [DW-1:0] mem_dout_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          inflight_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DW-1:0]           rd_data_q;

  // Stage READ_LATENCY-2 marks the cycle in which mem_dout carries the beat.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      vld_q     <= '0;
      rd_data_q <= '0;
    end else begin
      vld_q <= {vld_q[READ_LATENCY-2:0], issue_i};
      if (vld_q[READ_LATENCY-2]) rd_data_q <= mem_dout_i;
    end
  end

  assign rd_valid_o = vld_q[READ_LATENCY-1] && !flush_i;
  assign rd_data_o  = rd_data_q;
  assign inflight_o = |vld_q[READ_LATENCY-2:0];

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator: accepts a request over valid/ready, then streams write beats
// into the memory or read beats out of it with addresses wrapping modulo 2**AW.
// Optional macro MEMBURST_CHECKSUM_EN adds a per-burst XOR checksum output csum.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; ready
// never depends on valid, and a request's fields must stay stable until accepted.
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output state_e        dbg_state
`ifdef MEMBURST_CHECKSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          req_fire, wr_fire, rd_issue, rd_inflight;

  // Every output that can start or finish a transfer is gated by rst so the
  // reset cycle itself is quiet.
  assign req_ready = (state_q == IDLE) && !rst;
  assign req_fire  = req_ready && req_valid;
  assign wr_ready  = (state_q == WRITE) && !rst;
  assign wr_fire   = wr_ready && wr_valid;
  assign rd_issue  = (state_q == READ) && !rst;
  assign done      = (state_q == DONE) && !rst;
  assign mem_we    = wr_fire;
  assign mem_din   = (state_q == WRITE) ? wr_data : '0;
  assign mem_addr  = addr_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          addr_d  = req_addr;
          rem_d   = req_len;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == '0) state_d = DONE;
        end
      end
      READ: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == '0) state_d = DRAIN;
      end
      // Leave once the last beat is on rd_valid and nothing is behind it.
      DRAIN: begin
        if (rd_valid && !rd_inflight) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_burst_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk        (clk),
    .flush_i    (rst),
    .issue_i    (rd_issue),
    .mem_dout_i (mem_dout),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .inflight_o (rd_inflight)
  );

`ifdef MEMBURST_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)           csum_q <= '0;
    else if (req_fire) csum_q <= '0;
    else if (wr_fire)  csum_q <= csum_q ^ wr_data;
    else if (rd_valid) csum_q <= csum_q ^ rd_data;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Bench for mem_burst_initiator: a 16x8 memory, directed and random bursts,
// and a reference model that predicts each beat from address/length arithmetic.
module tb_mem_burst_initiator;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write;
  logic       req_ready;
  logic [3:0] req_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;
  state_e     dbg_state;
`ifdef MEMBURST_CHECKSUM_EN
  logic [7:0] csum;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem       [16];
  logic [7:0] model_mem [16];
  logic [7:0] wdata_q[$];
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_burst_initiator dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .dbg_state (dbg_state)
`ifdef MEMBURST_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // External 16x8 memory with registered read data.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else        mem_dout      <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic wr, input logic [3:0] a, input logic [3:0] len);
    bit got = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1;
      tick();
    end
    req_valid = 1'b0;
    check("req_accept", 32'(got), 32'd1);
  endtask

  // mode 0: wr_valid always high, 1: toggling 1,0,1,0..., 2: random
  task automatic do_write(input logic [3:0] a, input logic [3:0] len, input int mode);
    int beats = int'(len) + 1;
    int idx = 0;
    int t = 0;
    logic [7:0] x = 8'h00;
    send_req(1'b1, a, len);
    while (idx < beats && t < 200) begin
      wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
      wr_data  = wdata_q[idx];
      @(negedge clk);
      check("wr_ready", 32'(wr_ready), 32'd1);
      check("mem_we", 32'(mem_we), 32'(wr_valid));
      check("wr_addr", 32'(mem_addr), 32'((int'(a) + idx) % 16));
      if (wr_valid) check("mem_din", 32'(mem_din), 32'(wdata_q[idx]));
      check("wr_done_early", 32'(done), 32'd0);
      tick();
      if (wr_valid) begin
        model_mem[(int'(a) + idx) % 16] = wdata_q[idx];
        x = x ^ wdata_q[idx];
        idx++;
      end
      t++;
    end
    wr_valid = 1'b0;
    check("wr_beats_timeout", 32'(idx), 32'(beats));
    @(negedge clk);
    check("wr_done", 32'(done), 32'd1);
    check("wr_done_we", 32'(mem_we), 32'd0);
    check("wr_done_ready", 32'(req_ready), 32'd0);
`ifdef MEMBURST_CHECKSUM_EN
    check("wr_csum", 32'(csum), 32'(x));
`endif
    tick();
    @(negedge clk);
    check("wr_after_done", 32'(done), 32'd0);
    check("wr_idle_ready", 32'(req_ready), 32'd1);
    tick();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] len);
    int n = int'(len) + 1;
    logic [7:0] x = 8'h00;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model_mem[(int'(a) + k) % 16]);
    send_req(1'b0, a, len);
    // Beat k is addressed in cycle k and returned in cycle k+2; done follows the last.
    for (int t = 0; t <= n + 2; t++) begin
      @(negedge clk);
      if (t < n) begin
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'((int'(a) + t) % 16));
      end
      check("rd_valid", 32'(rd_valid), 32'((t >= 2) && (t <= n + 1)));
      if (t >= 2 && t <= n + 1) begin
        check("rd_data", 32'(rd_data), 32'(exp_q[t - 2]));
        x = x ^ exp_q[t - 2];
      end
      check("rd_done", 32'(done), 32'(t == n + 2));
`ifdef MEMBURST_CHECKSUM_EN
      if (t == n + 2) check("rd_csum", 32'(csum), 32'(x));
`endif
      tick();
    end
    @(negedge clk);
    check("rd_idle_ready", 32'(req_ready), 32'd1);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]       = 8'h00;
      model_mem[i] = 8'h00;
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'd0);
    check("post_rst_rd_data", 32'(rd_data), 32'd0);
    check("post_rst_wr_ready", 32'(wr_ready), 32'd0);
`ifdef MEMBURST_CHECKSUM_EN
    check("post_rst_csum", 32'(csum), 32'd0);
`endif
    tick();

    // Write beat offered while idle is not consumed.
    wr_valid = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    check("idle_wr_ready", 32'(wr_ready), 32'd0);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    tick();
    wr_valid = 1'b0;

    wdata_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(4'd3, 4'd3, 0);
    do_read(4'd3, 4'd3);

    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back(8'($urandom));
    do_write(4'd14, 4'd3, 1);
    do_read(4'd14, 4'd3);

    wdata_q = '{8'h5A};
    do_write(4'd9, 4'd0, 0);
    do_read(4'd9, 4'd0);
    do_read(4'd0, 4'd15);

    // Reset in the middle of an 8-beat read, after two beats returned.
    begin
      logic [3:0] ra = 4'($urandom);
      send_req(1'b0, ra, 4'd7);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        check("mid_rd_valid", 32'(rd_valid), 32'(t >= 2));
        if (t >= 2) check("mid_rd_data", 32'(rd_data), 32'(model_mem[(int'(ra) + t - 2) % 16]));
        check("mid_done", 32'(done), 32'd0);
        tick();
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_rd_valid", 32'(rd_valid), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_mem_we", 32'(mem_we), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready_after", 32'(req_ready), 32'd1);
      for (int t = 0; t < 6; t++) begin
        check("abort_no_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        tick();
        @(negedge clk);
      end
      tick();
    end
    do_read(4'd3, 4'd3);

    wdata_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    do_write(4'd5, 4'd3, 0);
    do_read(4'd5, 4'd3);

    for (int b = 0; b < 10; b++) begin
      logic [3:0] a   = 4'($urandom);
      logic [3:0] len = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wdata_q.delete();
        for (int i = 0; i <= int'(len); i++) wdata_q.push_back(8'($urandom));
        do_write(a, len, $urandom_range(0, 2));
      end else begin
        do_read(a, len);
      end
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
